// File: rtl/agu_sched_pkg.sv
// Shared types and helpers for the AGU scheduler: memory access size, alignment check, index width.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package agu_sched_pkg;

  // Access size carried with each memory op; encoding 3 is reserved and behaves as WORD.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  // Width of an encoded requester index; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Alignment only depends on the two low address bits, so callers pass just those.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (mem_size_t'(size))
      BYTE:    return 1'b0;
      HALF:    return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/agu_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer (wrapping) wins.
// Latency: purely combinational.
// Backpressure: en_i low suppresses the one-hot grant; idx_o/any_o still report the winner.
module rr_arbiter
  import agu_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int SRC_W  = src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0]   idx_o,
  output logic               any_o
);

  int j;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = SRC_W'(j);
      end
    end
    if (en_i && any_o) begin
      gnt_o = NUM_REQ'(1) << idx_o;
    end
  end

endmodule

// File: rtl/agu_scheduler.sv
// Shares one combinational AGU among NUM_REQ issue requesters (round-robin), registers result in a 1-entry stage.
// Latency: 1 cycle grant->out_valid; 1 op/cycle while out_ready is held high. Optional perf counters: AGU_SCHED_PERF_EN.
// Backpressure: no grant while the output entry is stalled (out_valid & !out_ready) or during flush/reset.
module agu_scheduler
  import agu_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  localparam int SRC_W     = src_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
  input  logic [NUM_REQ*2-1:0]          req_size,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          agu_valid,
  output logic [DATA_WIDTH-1:0]         agu_op1,
  output logic [DATA_WIDTH-1:0]         agu_op2,
  input  logic                          agu_res_valid,
  input  logic [DATA_WIDTH-1:0]         agu_result,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_addr,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [SRC_W-1:0]              out_src,
  output logic                          out_misalign,
  input  logic                          out_ready
`ifdef AGU_SCHED_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_grants,
  output logic [31:0]                   perf_conflicts
`endif
);

  logic                  can_accept;
  logic                  accept;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic [1:0]            sel_size;
  logic [TAG_WIDTH-1:0]  sel_tag;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic [TAG_WIDTH-1:0]  out_tag_q,   out_tag_d;
  logic [SRC_W-1:0]      out_src_q,   out_src_d;
  logic                  out_mis_q,   out_mis_d;
  logic [SRC_W-1:0]      rr_ptr_q,    rr_ptr_d;

  // Reset is folded in so req_ready drops the instant rst rises, not at the next edge.
  assign can_accept = !rst && !flush && (!out_valid_q || out_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (can_accept),
    .gnt_o (req_ready),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign agu_valid = |req_ready;
  assign accept    = agu_valid;

  // Steer the granted requester's operands/size/tag; zeros when nothing is granted.
  always_comb begin
    agu_op1  = '0;
    agu_op2  = '0;
    sel_size = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        agu_op1  = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
        agu_op2  = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
        sel_size = req_size[i*2 +: 2];
        sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  // Next state of the output entry and round-robin pointer; accept wins over drain, flush only clears.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_tag_d   = out_tag_q;
    out_src_d   = out_src_q;
    out_mis_d   = out_mis_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = agu_result;
      out_tag_d   = sel_tag;
      out_src_d   = gnt_idx;
      out_mis_d   = misaligned(agu_result[1:0], sel_size);
      rr_ptr_d    = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (flush || out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output entry and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_tag_q   <= '0;
      out_src_q   <= '0;
      out_mis_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_tag_q   <= out_tag_d;
      out_src_q   <= out_src_d;
      out_mis_q   <= out_mis_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_tag      = out_tag_q;
  assign out_src      = out_src_q;
  assign out_misalign = out_mis_q;

  // The AGU is combinational; its result must be valid in the same cycle the scheduler accepts.
  a_agu_res_valid: assert property (@(posedge clk) disable iff (rst) accept |-> agu_res_valid);

`ifdef AGU_SCHED_PERF_EN
  logic [31:0] grants_q [NUM_REQ];
  logic [31:0] conflicts_q;
  int          n_valid;
  logic        conflict;

  // A conflict cycle: two or more requesters competing while the output stage could take one.
  always_comb begin
    n_valid = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_valid = n_valid + int'(req_valid[i]);
    end
    conflict = (n_valid >= 2) && can_accept;
  end

  // Saturating per-requester accept counters and conflict counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grants_q[i] <= '0;
      end
      conflicts_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (grants_q[i] != '1)) begin
          grants_q[i] <= grants_q[i] + 32'd1;
        end
      end
      if (conflict && (conflicts_q != '1)) begin
        conflicts_q <= conflicts_q + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf_grants[g*32 +: 32] = grants_q[g];
  end
  assign perf_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_agu_scheduler.sv
// Directed bench for agu_scheduler: transaction-level model checked every cycle plus literal spot checks.
// Latency: n/a.
// Backpressure: exercises stall, flush and reset on the output stage.
module tb_agu_scheduler;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int TW = 6;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_op1;
  logic [N*DW-1:0] req_op2;
  logic [N*2-1:0]  req_size;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic            agu_valid;
  logic [DW-1:0]   agu_op1;
  logic [DW-1:0]   agu_op2;
  logic            agu_res_valid;
  logic [DW-1:0]   agu_result;
  logic            out_valid;
  logic [DW-1:0]   out_addr;
  logic [TW-1:0]   out_tag;
  logic [0:0]      out_src;
  logic            out_misalign;
  logic            out_ready;
`ifdef AGU_SCHED_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_conflicts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  agu_scheduler #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_size(req_size), .req_tag(req_tag), .req_ready(req_ready),
    .agu_valid(agu_valid), .agu_op1(agu_op1), .agu_op2(agu_op2),
    .agu_res_valid(agu_res_valid), .agu_result(agu_result),
    .out_valid(out_valid), .out_addr(out_addr), .out_tag(out_tag),
    .out_src(out_src), .out_misalign(out_misalign), .out_ready(out_ready)
`ifdef AGU_SCHED_PERF_EN
    , .perf_grants(perf_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  // Environment AGU: plain combinational adder.
  assign agu_res_valid = agu_valid;
  assign agu_result    = agu_op1 + agu_op2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_addr  = '0;
  logic [TW-1:0] m_tag   = '0;
  int            m_src   = 0;
  logic          m_mis   = 1'b0;
  int            m_ptr   = 0;
  logic [31:0]   m_grants [N];
  logic [31:0]   m_conf  = '0;

  function automatic logic model_can();
    return !rst && !flush && (!m_valid || out_ready);
  endfunction

  function automatic int model_grant();
    if (!model_can()) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    int g;
    logic [DW-1:0] a;
    logic [1:0] sz;
    if (rst) begin
      m_valid = 1'b0; m_addr = '0; m_tag = '0; m_src = 0; m_mis = 1'b0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_grants[i] = '0;
      m_conf = '0;
    end else begin
      g = model_grant();
      if ($countones(req_valid) >= 2 && model_can() && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
      if (g >= 0) begin
        a  = req_op1[g*DW +: DW] + req_op2[g*DW +: DW];
        sz = req_size[g*2 +: 2];
        m_valid = 1'b1;
        m_addr  = a;
        m_tag   = req_tag[g*TW +: TW];
        m_src   = g;
        m_mis   = (sz == 2'd0) ? 1'b0 : (sz == 2'd1) ? a[0] : (a[1:0] != 2'b00);
        m_ptr   = (g + 1) % N;
        if (m_grants[g] != 32'hFFFF_FFFF) m_grants[g] = m_grants[g] + 1;
      end else if (flush || out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison, half a cycle after the active edge.
  always @(negedge clk) begin : cmp
    int g;
    logic [N-1:0] er;
    g  = model_grant();
    er = (g >= 0) ? N'(1) << g : '0;
    chk("req_ready", req_ready, er);
    chk("agu_valid", agu_valid, (g >= 0));
    chk("agu_op1", agu_op1, (g >= 0) ? req_op1[g*DW +: DW] : '0);
    chk("agu_op2", agu_op2, (g >= 0) ? req_op2[g*DW +: DW] : '0);
    chk("out_valid", out_valid, m_valid);
    if (m_valid || rst) begin
      chk("out_addr", out_addr, m_addr);
      chk("out_tag", out_tag, m_tag);
      chk("out_src", out_src, m_src);
      chk("out_misalign", out_misalign, m_mis);
    end
`ifdef AGU_SCHED_PERF_EN
    for (int i = 0; i < N; i++) chk("perf_grants", perf_grants[i*32 +: 32], m_grants[i]);
    chk("perf_conflicts", perf_conflicts, m_conf);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] sz, input logic [5:0] tg);
    req_op1[i*DW +: DW] = a;
    req_op2[i*DW +: DW] = b;
    req_size[i*2 +: 2]  = sz;
    req_tag[i*TW +: TW] = tg;
  endtask

  logic [N-1:0] gseq [4];
  logic [31:0]  t5_a [4] = '{32'h0000_2000, 32'h0000_2000, 32'hFFFF_FFFF, 32'h0000_2000};
  logic [31:0]  t5_b [4] = '{32'h2, 32'h3, 32'h1, 32'h2};
  logic [1:0]   t5_s [4] = '{2'd2, 2'd0, 2'd2, 2'd3};
  logic [31:0]  t5_e [4] = '{32'h0000_2002, 32'h0000_2003, 32'h0, 32'h0000_2002};
  logic         t5_m [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; out_ready = 1'b1;
    req_op1 = '0; req_op2 = '0; req_size = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Single req 0: 0x1000 + (-4), WORD; first grant after reset goes to req 0.
    set_req(0, 32'h0000_1000, 32'hFFFF_FFFC, 2'd2, 6'd5);
    req_valid = 2'b01;
    #1 chk("first_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_addr", out_addr, 32'h0000_0FFC);
    chk("t2_mis", out_misalign, 1'b0);
    chk("t2_src", out_src, 1'b0);
    chk("t2_tag", out_tag, 6'd5);

    // Req 1, HALF at 0x2001 (also moves the pointer back to 0).
    set_req(1, 32'h0000_2000, 32'h1, 2'd1, 6'd9);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    chk("half_addr", out_addr, 32'h0000_2001);
    chk("half_mis", out_misalign, 1'b1);
    chk("half_src", out_src, 1'b1);

    // Both requesting for 4 cycles: alternating grants, one output per cycle.
    set_req(0, 32'h100, 32'h0, 2'd0, 6'd1);
    set_req(1, 32'h200, 32'h0, 2'd0, 6'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 gseq[k] = req_ready;
      step();
      chk("rr_out_valid", out_valid, 1'b1);
    end
    req_valid = '0;
    chk("rr_g0", gseq[0], 2'b01);
    chk("rr_g1", gseq[1], 2'b10);
    chk("rr_g2", gseq[2], 2'b01);
    chk("rr_g3", gseq[3], 2'b10);
    chk("rr_last_addr", out_addr, 32'h200);
`ifdef AGU_SCHED_PERF_EN
    chk("perf_conf4", perf_conflicts, 32'd4);
    chk("perf_g0", perf_grants[31:0], 32'd3);
    chk("perf_g1", perf_grants[63:32], 32'd3);
`endif

    // Stall 3 cycles: no grant, entry held; release drains and refills on the same edge.
    out_ready = 1'b0;
    set_req(0, 32'h0000_3000, 32'h10, 2'd2, 6'd7);
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", req_ready, 2'b00);
      step();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_addr", out_addr, 32'h200);
      chk("stall_tag", out_tag, 6'd2);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("refill_valid", out_valid, 1'b1);
    chk("refill_addr", out_addr, 32'h0000_3010);
    chk("refill_tag", out_tag, 6'd7);

    // Alignment table through req 0.
    for (int k = 0; k < 4; k++) begin
      set_req(0, t5_a[k], t5_b[k], t5_s[k], 6'(k + 20));
      req_valid = 2'b01;
      step();
      req_valid = '0;
      chk("align_addr", out_addr, t5_e[k]);
      chk("align_mis", out_misalign, t5_m[k]);
    end

    // Flush with a pending request and out_ready=1: no grant, entry dropped, pointer kept (at 1).
    set_req(0, 32'h40, 32'h0, 2'd2, 6'd11);
    set_req(1, 32'h80, 32'h0, 2'd2, 6'd12);
    req_valid = 2'b11;
    flush = 1'b1;
    #1 chk("flush_ready", req_ready, 2'b00);
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    #1 chk("post_flush_grant", req_ready, 2'b10);
    step();
    chk("post_flush_src", out_src, 1'b1);
    chk("post_flush_addr", out_addr, 32'h80);

    // Reset mid-stream: entry and grant vanish immediately; pointer back to 0.
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    step();
    rst = 1'b0;
    #1 chk("post_rst_grant", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("post_rst_src", out_src, 1'b0);
    chk("post_rst_addr", out_addr, 32'h40);
`ifdef AGU_SCHED_PERF_EN
    chk("perf_conf_rst", perf_conflicts, 32'd1);
    chk("perf_g0_rst", perf_grants[31:0], 32'd1);
    chk("perf_g1_rst", perf_grants[63:32], 32'd0);
`endif
    step();
    chk("drain_valid", out_valid, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
